async_fifo_rd_packer: RTL and testbench

Read-side consumer for the asynchronous FIFO. It sits in the `rclk` domain on the FIFO read port, pops bytes whenever the FIFO is non-empty, and packs them little-endian into `NBYTES`-byte words. Words are presented on a valid/ready output with a byte count. A flush request forces a partially assembled word out.

---
 rtl/async_fifo_rd_packer.sv | 104 ++++++++++
 tb/tb_async_fifo_rd_packer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_rd_packer.sv
`default_nettype none
// ============================================================================
// Module   : async_fifo_rd_packer
// Purpose  : Pops bytes from the read port of an async FIFO and packs them
//            little-endian into NBYTES-byte words on a valid/ready output,
//            with a flush that forces out a partially assembled word.
// Revision : 1.0 - initial release
// ============================================================================
module async_fifo_rd_packer #(
    parameter int NBYTES = 4
) (
    input  logic                         rclk,
    input  logic                         reset_L,
    output logic                         pop,
    input  logic [7:0]                   rdata,
    input  logic                         empty,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [8*NBYTES-1:0]          out_data,
    output logic [$clog2(NBYTES+1)-1:0]  out_nbytes,
    input  logic                         flush,
    output logic                         flush_done
);

    localparam int c_CNT_W = $clog2(NBYTES+1);

    logic [8*NBYTES-1:0] r_asm;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_pend;
    logic                r_out_valid;
    logic [8*NBYTES-1:0] r_out_data;
    logic [c_CNT_W-1:0]  r_out_nbytes;
    logic                r_flush_req;

    logic [c_CNT_W:0]    w_fill;
    logic                w_xfer_full;
    logic                w_flush_go;
    logic                w_flush_emit;
    logic                w_pop;

    // Counting the in-flight byte keeps asm from ever overflowing.
    assign w_fill      = {1'b0, r_cnt} + {{c_CNT_W{1'b0}}, r_pend};
    assign w_xfer_full = (r_cnt == c_CNT_W'(NBYTES)) && !r_out_valid;

    // A full asm at flush time takes the normal transfer path first.
    assign w_flush_go   = r_flush_req && !r_pend && !r_out_valid &&
                          (r_cnt != c_CNT_W'(NBYTES));
    assign w_flush_emit = w_flush_go && (r_cnt != '0);

    assign w_pop = reset_L && !empty && !r_flush_req && !flush &&
                   ((w_fill < (c_CNT_W+1)'(NBYTES)) || w_xfer_full);

    always_ff @(posedge rclk or negedge reset_L) begin
        if (!reset_L) begin
            r_asm        <= '0;
            r_cnt        <= '0;
            r_pend       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_nbytes <= '0;
            r_flush_req  <= 1'b0;
        end else begin
            r_pend <= w_pop;

            if (w_xfer_full || w_flush_emit) begin
                r_asm <= '0;
                r_cnt <= '0;
            end else if (r_pend) begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (r_cnt == c_CNT_W'(i)) begin
                        r_asm[8*i +: 8] <= rdata;
                    end
                end
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_xfer_full) begin
                r_out_data   <= r_asm;
                r_out_nbytes <= c_CNT_W'(NBYTES);
                r_out_valid  <= 1'b1;
            end else if (w_flush_emit) begin
                r_out_data   <= r_asm;
                r_out_nbytes <= r_cnt;
                r_out_valid  <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid  <= 1'b0;
            end

            if (w_flush_go) begin
                r_flush_req <= 1'b0;
            end else if (flush) begin
                r_flush_req <= 1'b1;
            end
        end
    end

    assign pop        = w_pop;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_nbytes = r_out_nbytes;
    assign flush_done = w_flush_go;

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_rd_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_async_fifo_rd_packer
// Purpose  : Bench for async_fifo_rd_packer: FIFO model, word grouping model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_async_fifo_rd_packer;

    localparam int NB = 4;
    localparam int CW = $clog2(NB+1);

    logic            rclk = 1'b0;
    logic            reset_L = 1'b0;
    logic            pop;
    logic [7:0]      rdata = 8'h00;
    logic            empty = 1'b1;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [8*NB-1:0] out_data;
    logic [CW-1:0]   out_nbytes;
    logic            flush = 1'b0;
    logic            flush_done;

    async_fifo_rd_packer #(.NBYTES(NB)) dut (
        .rclk       (rclk),
        .reset_L    (reset_L),
        .pop        (pop),
        .rdata      (rdata),
        .empty      (empty),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_nbytes (out_nbytes),
        .flush      (flush),
        .flush_done (flush_done)
    );

    always #5 rclk = ~rclk;

    int n_tests = 0;
    int n_fail  = 0;

    byte unsigned    fifo_q[$];
    byte unsigned    src[$];
    logic [8*NB-1:0] got_data[$];
    logic [CW-1:0]   got_nb[$];
    int              popped, cyc, pop_viol, fd_cnt;
    bit              gap;

    logic            s_pop, s_ov, s_fd;
    logic [8*NB-1:0] s_data;
    logic [CW-1:0]   s_nb;
    int              s_cyc;

    // One cycle, entered and left at the negedge. The FIFO model returns the
    // popped byte after the posedge, so it is valid through the next posedge.
    task automatic tick(input bit ordy, input bit fl);
        out_ready = ordy;
        flush     = fl;
        empty     = (fifo_q.size() == 0) || gap;
        #1;
        s_pop = pop; s_ov = out_valid; s_fd = flush_done;
        s_data = out_data; s_nb = out_nbytes; s_cyc = cyc;
        if (s_pop === 1'b1 && empty) pop_viol++;
        if (s_fd === 1'b1) fd_cnt++;
        @(posedge rclk); #1;
        if (s_pop === 1'b1 && fifo_q.size() > 0) begin
            rdata = fifo_q.pop_front();
            popped++;
        end else begin
            rdata = 8'($urandom);
        end
        if (s_ov === 1'b1 && ordy) begin
            got_data.push_back(s_data);
            got_nb.push_back(s_nb);
        end
        flush = 1'b0;
        cyc++;
        @(negedge rclk);
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        fifo_q.delete(); src.delete(); got_data.delete(); got_nb.delete();
        popped = 0; cyc = 0; pop_viol = 0; fd_cnt = 0; gap = 1'b0;
        flush = 1'b0; out_ready = 1'b0; empty = 1'b1;
        @(negedge rclk); @(negedge rclk);
        reset_L = 1'b1;
        @(negedge rclk);
    endtask

    // Reference model: source bytes grouped little-endian into NB-byte words.
    function automatic logic [8*NB-1:0] model_word(input int w);
        logic [8*NB-1:0] v = '0;
        for (int j = 0; j < NB; j++) begin
            if (NB*w + j < src.size()) v[8*j +: 8] = src[NB*w + j];
        end
        return v;
    endfunction

    task automatic load_src();
        foreach (src[i]) fifo_q.push_back(src[i]);
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        fifo_q.delete(); fifo_q.push_back(8'h11);
        empty = 1'b0; out_ready = 1'b1; flush = 1'b1;
        @(negedge rclk); #1;
        n_tests++; if (pop !== 1'b0)        begin n_fail++; $display("FAIL reset_pop: got %b want 0", pop); end
        n_tests++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_tests++; if (out_data !== '0)     begin n_fail++; $display("FAIL reset_data: got %h want 0", out_data); end
        n_tests++; if (out_nbytes !== '0)   begin n_fail++; $display("FAIL reset_nbytes: got %0d want 0", out_nbytes); end
        n_tests++; if (flush_done !== 1'b0) begin n_fail++; $display("FAIL reset_flush_done: got %b want 0", flush_done); end
        flush = 1'b0;
    endtask

    task automatic test_stream();
        int rise[$];
        logic prev_ov;
        do_reset();
        for (int i = 0; i < 12; i++) src.push_back(8'(i));
        load_src();
        prev_ov = 1'b0;
        for (int i = 0; i < 80 && got_data.size() < 3; i++) begin
            tick(1'b1, 1'b0);
            if (s_ov === 1'b1 && prev_ov !== 1'b1) rise.push_back(s_cyc);
            prev_ov = s_ov;
        end
        n_tests++; if (got_data.size() != 3) begin n_fail++; $display("FAIL stream_count: got %0d want 3", got_data.size()); end
        for (int w = 0; w < got_data.size() && w < 3; w++) begin
            n_tests++;
            if (got_data[w] !== model_word(w) || got_nb[w] !== CW'(NB)) begin
                n_fail++; $display("FAIL stream_word%0d: got %h/%0d want %h/%0d", w, got_data[w], got_nb[w], model_word(w), NB);
            end
        end
        n_tests++; if (rise.size() < 2 || rise[0] != NB+2 || rise[1] != 2*NB+3) begin
            n_fail++; $display("FAIL stream_timing: got first rise %0d second %0d want %0d %0d",
                               rise.size() > 0 ? rise[0] : -1, rise.size() > 1 ? rise[1] : -1, NB+2, 2*NB+3);
        end
        n_tests++; if (pop_viol != 0) begin n_fail++; $display("FAIL stream_pop_empty: got %0d want 0", pop_viol); end

        // Random bytes, random empty gaps and random backpressure.
        do_reset();
        for (int i = 0; i < 40; i++) src.push_back(8'($urandom));
        load_src();
        for (int i = 0; i < 800 && got_data.size() < 10; i++) begin
            gap = ($urandom_range(0, 3) == 0);
            tick(($urandom_range(0, 2) != 0), 1'b0);
        end
        gap = 1'b0;
        n_tests++; if (got_data.size() != 10) begin n_fail++; $display("FAIL rand_count: got %0d want 10", got_data.size()); end
        for (int w = 0; w < got_data.size() && w < 10; w++) begin
            n_tests++;
            if (got_data[w] !== model_word(w) || got_nb[w] !== CW'(NB)) begin
                n_fail++; $display("FAIL rand_word%0d: got %h/%0d want %h/%0d", w, got_data[w], got_nb[w], model_word(w), NB);
            end
        end
        n_tests++; if (pop_viol != 0) begin n_fail++; $display("FAIL rand_pop_empty: got %0d want 0", pop_viol); end
    endtask

    task automatic test_backpressure();
        int unstable;
        do_reset();
        for (int i = 0; i < 12; i++) src.push_back(8'(i));
        load_src();
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0);
            if (s_ov === 1'b1 && s_data !== model_word(0)) unstable++;
        end
        n_tests++; if (popped != 2*NB) begin n_fail++; $display("FAIL bp_popped: got %0d want %0d", popped, 2*NB); end
        n_tests++; if (s_ov !== 1'b1 || unstable != 0) begin
            n_fail++; $display("FAIL bp_hold: got valid %b unstable %0d want valid 1 unstable 0", s_ov, unstable);
        end
        for (int i = 0; i < 60 && got_data.size() < 3; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
        n_tests++; if (got_data.size() != 3) begin n_fail++; $display("FAIL bp_count: got %0d want 3", got_data.size()); end
        for (int w = 0; w < got_data.size() && w < 3; w++) begin
            n_tests++;
            if (got_data[w] !== model_word(w) || got_nb[w] !== CW'(NB)) begin
                n_fail++; $display("FAIL bp_word%0d: got %h/%0d want %h/%0d", w, got_data[w], got_nb[w], model_word(w), NB);
            end
        end
    endtask

    task automatic test_flush_partial();
        int lat;
        do_reset();
        src = '{8'hAA, 8'hBB, 8'hCC};
        load_src();
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0);
            if (s_fd === 1'b1 && lat < 0) lat = i + 1;
        end
        n_tests++; if (lat != 1) begin n_fail++; $display("FAIL fp_latency: got %0d want 1", lat); end
        n_tests++; if (fd_cnt != 1) begin n_fail++; $display("FAIL fp_done_pulses: got %0d want 1", fd_cnt); end
        n_tests++; if (got_data.size() != 1 || got_data[0] !== 32'h00CCBBAA || got_nb[0] !== CW'(3)) begin
            n_fail++; $display("FAIL fp_word: got n=%0d %h/%0d want n=1 00ccbbaa/3", got_data.size(),
                               got_data.size() > 0 ? got_data[0] : '0, got_nb.size() > 0 ? got_nb[0] : '0);
        end
        src = '{8'h01, 8'h02, 8'h03, 8'h04};
        load_src();
        for (int i = 0; i < 30 && got_data.size() < 2; i++) tick(1'b1, 1'b0);
        n_tests++; if (got_data.size() != 2 || got_data[1] !== model_word(0) || got_nb[1] !== CW'(NB)) begin
            n_fail++; $display("FAIL fp_restart: got n=%0d %h want n=2 %h", got_data.size(),
                               got_data.size() > 1 ? got_data[1] : '0, model_word(0));
        end
    endtask

    task automatic test_flush_edge();
        int pop_at_fd;
        // Empty asm, idle pipeline: flush blocks the same-cycle pop.
        do_reset();
        src = '{8'h5A, 8'hA5};
        load_src();
        tick(1'b1, 1'b1);
        n_tests++; if (s_pop !== 1'b0) begin n_fail++; $display("FAIL fe_pop_same_cycle: got %b want 0", s_pop); end
        tick(1'b1, 1'b0);
        n_tests++; if (s_fd !== 1'b1 || s_pop !== 1'b0) begin
            n_fail++; $display("FAIL fe_empty_done: got done %b pop %b want done 1 pop 0", s_fd, s_pop);
        end
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
        n_tests++; if (got_data.size() != 0 || fd_cnt != 1 || popped != 2) begin
            n_fail++; $display("FAIL fe_empty_noword: got words %0d done %0d popped %0d want 0 1 2", got_data.size(), fd_cnt, popped);
        end

        // Flush in the cycle after the last pop of a full word.
        do_reset();
        for (int i = 0; i < 6; i++) src.push_back(8'(8'h10 + i));
        load_src();
        for (int i = 0; i < NB; i++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        pop_at_fd = -1;
        for (int i = 0; i < 14; i++) begin
            tick(1'b1, 1'b0);
            if (s_fd === 1'b1 && pop_at_fd < 0) pop_at_fd = popped;
        end
        n_tests++; if (got_data.size() != 1 || got_data[0] !== model_word(0) || got_nb[0] !== CW'(NB)) begin
            n_fail++; $display("FAIL fe_full_word: got n=%0d %h want n=1 %h/4", got_data.size(),
                               got_data.size() > 0 ? got_data[0] : '0, model_word(0));
        end
        n_tests++; if (fd_cnt != 1 || pop_at_fd != NB) begin
            n_fail++; $display("FAIL fe_full_done: got pulses %0d popped %0d want 1 %0d", fd_cnt, pop_at_fd, NB);
        end
    endtask

    task automatic test_empty_gaps();
        do_reset();
        for (int i = 0; i < 12; i++) src.push_back(8'($urandom));
        load_src();
        for (int i = 0; i < 120 && got_data.size() < 3; i++) begin
            gap = ((i / 2) % 2) == 1;
            tick(1'b1, 1'b0);
        end
        gap = 1'b0;
        n_tests++; if (got_data.size() != 3) begin n_fail++; $display("FAIL gap_count: got %0d want 3", got_data.size()); end
        for (int w = 0; w < got_data.size() && w < 3; w++) begin
            n_tests++;
            if (got_data[w] !== model_word(w) || got_nb[w] !== CW'(NB)) begin
                n_fail++; $display("FAIL gap_word%0d: got %h/%0d want %h/%0d", w, got_data[w], got_nb[w], model_word(w), NB);
            end
        end
        n_tests++; if (pop_viol != 0) begin n_fail++; $display("FAIL gap_pop_empty: got %0d want 0", pop_viol); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 12; i++) src.push_back(8'($urandom));
        load_src();
        for (int i = 0; i < 2*NB+1; i++) tick(1'b0, 1'b0);
        n_tests++; if (s_ov !== 1'b1) begin n_fail++; $display("FAIL rm_pre_valid: got %b want 1", s_ov); end
        empty = 1'b0;
        reset_L = 1'b0;
        #1;
        n_tests++; if (pop !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || out_nbytes !== '0 || flush_done !== 1'b0) begin
            n_fail++; $display("FAIL rm_outputs: got pop %b valid %b data %h nb %0d done %b want all 0",
                               pop, out_valid, out_data, out_nbytes, flush_done);
        end
        @(posedge rclk); #1; rdata = 8'($urandom);
        @(negedge rclk);
        reset_L = 1'b1;
        // Bytes still in the FIFO model form the next clean word.
        src.delete();
        foreach (fifo_q[i]) src.push_back(fifo_q[i]);
        for (int i = 0; i < 30 && got_data.size() < 1; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
        n_tests++; if (got_data.size() != 1 || got_data[0] !== model_word(0) || got_nb[0] !== CW'(NB)) begin
            n_fail++; $display("FAIL rm_clean_word: got n=%0d %h want n=1 %h", got_data.size(),
                               got_data.size() > 0 ? got_data[0] : '0, model_word(0));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        @(negedge rclk);
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_partial();
        test_flush_edge();
        test_empty_gaps();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
